// File: rtl/vu_pkg.sv
// Shared definitions for the VU level meter and the VGA bar-drawing stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vu_pkg;

    // Default sample and bar widths, shared with the bar-drawing stage.
    localparam int VU_S_WIDTH = 12;
    localparam int VU_L_WIDTH = 4;

    // Meter FSM: accumulate a window maximum, then spend one cycle updating.
    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_UPDATE = 1'b1
    } vu_state_e;

endpackage : vu_pkg

// File: rtl/vu_abs_sat.sv
// Saturating magnitude of a signed two's-complement sample.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of the input.
//
// Ports:
//   i_sample : signed sample, S_WIDTH bits
//   o_mag    : |i_sample| as S_WIDTH-1 unsigned bits; the most negative
//              value saturates to all ones
module vu_abs_sat #(
    parameter int S_WIDTH = vu_pkg::VU_S_WIDTH
) (
    input  logic [S_WIDTH-1:0] i_sample,
    output logic [S_WIDTH-2:0] o_mag
);

    logic              w_sign;
    logic              w_is_min;
    logic [S_WIDTH-2:0] w_low;
    logic [S_WIDTH-2:0] w_neg;

    assign w_sign   = i_sample[S_WIDTH-1];
    assign w_low    = i_sample[S_WIDTH-2:0];
    // For a negative sample -2^(n-1) + low, the magnitude is 2^(n-1) - low,
    // which is just the (n-1)-bit negation of low whenever low is non-zero.
    assign w_neg    = (~w_low) + (S_WIDTH-1)'(1);
    // low == 0 with the sign set is the most negative value: it has no
    // representable magnitude, so clamp to full scale.
    assign w_is_min = w_sign && (w_low == '0);

    always_comb begin
        if (w_is_min) begin
            o_mag = '1;
        end else if (w_sign) begin
            o_mag = w_neg;
        end else begin
            o_mag = w_low;
        end
    end

endmodule : vu_abs_sat

// File: rtl/vu_level_meter.sv
// VU level meter: per-frame window peak -> decaying bar level + peak-hold marker.
// Latency: level/peak/level_valid appear 2 cycles after the frame_start that closes a window.
// Backpressure: sample_ready drops for the single UPDATE cycle and during reset.
//
// Ports:
//   pixel_clock  : sole clock
//   reset        : synchronous active-low reset
//   sample       : signed audio sample, S_WIDTH bits
//   sample_valid : sample offered
//   sample_ready : sample accepted when valid && ready
//   frame_start  : one-cycle pulse at start of vertical blanking
//   level        : current bar height
//   peak         : peak-hold marker height
//   level_valid  : one-cycle pulse when level/peak update
module vu_level_meter
    import vu_pkg::*;
#(
    parameter int S_WIDTH      = VU_S_WIDTH,
    parameter int L_WIDTH      = VU_L_WIDTH,
    parameter int HOLD_FRAMES  = 30,
    parameter int DECAY_FRAMES = 2
) (
    input  logic               pixel_clock,
    input  logic               reset,
    input  logic [S_WIDTH-1:0] sample,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic               frame_start,
    output logic [L_WIDTH-1:0] level,
    output logic [L_WIDTH-1:0] peak,
    output logic               level_valid
);

    // Counter widths sized so the load value always fits (never zero width).
    localparam int HW = $clog2(HOLD_FRAMES + 2);
    localparam int DW = $clog2(DECAY_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES);
    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_FRAMES - 1);

    vu_state_e          r_state;
    logic [S_WIDTH-2:0] r_win_max;
    logic [L_WIDTH-1:0] r_level;
    logic [L_WIDTH-1:0] r_peak;
    logic [HW-1:0]      r_hold_cnt;
    logic [DW-1:0]      r_decay_cnt;
    logic               r_level_valid;

    logic [S_WIDTH-2:0] w_mag;
    logic               w_accept;
    logic [L_WIDTH-1:0] w_raw;
    logic [L_WIDTH-1:0] w_level_next;
    logic [L_WIDTH-1:0] w_peak_next;
    logic [HW-1:0]      w_hold_next;
    logic [DW-1:0]      w_decay_next;

    vu_abs_sat #(
        .S_WIDTH (S_WIDTH)
    ) u_abs_sat (
        .i_sample (sample),
        .o_mag    (w_mag)
    );

    // Ready is gated by reset directly so it reads 0 in every reset cycle
    // and 1 in the very first cycle after reset is released.
    assign sample_ready = reset && (r_state == ST_ACCUM);
    assign w_accept     = sample_valid && sample_ready;

    // Top L_WIDTH bits of the window magnitude form the raw bar height.
    assign w_raw = r_win_max[S_WIDTH-2 -: L_WIDTH];

    // Bar level: jump up immediately, fall one step every DECAY_FRAMES frames.
    always_comb begin
        w_level_next = r_level;
        w_decay_next = r_decay_cnt;
        if (w_raw >= r_level) begin
            w_level_next = w_raw;
            w_decay_next = '0;
        end else if (r_decay_cnt >= DECAY_LAST) begin
            w_level_next = (r_level == '0) ? '0 : r_level - L_WIDTH'(1);
            w_decay_next = '0;
        end else begin
            w_decay_next = r_decay_cnt + DW'(1);
        end
    end

    // Peak marker: capture and hold, then fall one step per frame, never
    // below the new bar level.
    always_comb begin
        w_peak_next = r_peak;
        w_hold_next = r_hold_cnt;
        if (w_level_next >= r_peak) begin
            w_peak_next = w_level_next;
            w_hold_next = HOLD_LOAD;
        end else if (r_hold_cnt != '0) begin
            w_hold_next = r_hold_cnt - HW'(1);
        end else begin
            w_peak_next = (r_peak == '0) ? '0 : r_peak - L_WIDTH'(1);
            if (w_peak_next < w_level_next) begin
                w_peak_next = w_level_next;
            end
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (!reset) begin
            r_state       <= ST_ACCUM;
            r_win_max     <= '0;
            r_level       <= '0;
            r_peak        <= '0;
            r_hold_cnt    <= '0;
            r_decay_cnt   <= '0;
            r_level_valid <= 1'b0;
        end else begin
            r_level_valid <= 1'b0;
            case (r_state)
                ST_ACCUM: begin
                    // A sample accepted alongside frame_start still lands
                    // in the window being closed.
                    if (w_accept && (w_mag > r_win_max)) begin
                        r_win_max <= w_mag;
                    end
                    if (frame_start) begin
                        r_state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    // frame_start is deliberately ignored here.
                    r_win_max     <= '0;
                    r_level       <= w_level_next;
                    r_peak        <= w_peak_next;
                    r_hold_cnt    <= w_hold_next;
                    r_decay_cnt   <= w_decay_next;
                    r_level_valid <= 1'b1;
                    r_state       <= ST_ACCUM;
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    assign level       = r_level;
    assign peak        = r_peak;
    assign level_valid = r_level_valid;

endmodule : vu_level_meter

// File: tb/tb_vu_level_meter.sv
// Scoreboard bench for vu_level_meter (HOLD_FRAMES=3, DECAY_FRAMES=1).
// Stimulus pushes expected {cycle, level, peak}; a negedge monitor pops on level_valid.
// Directed vectors with hand-computed expectations.
module tb_vu_level_meter;

    localparam int SW = 12;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] sample;
    logic          sample_valid;
    logic          sample_ready;
    logic          frame_start;
    logic [LW-1:0] level;
    logic [LW-1:0] peak;
    logic          level_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int            cyc;
        logic [LW-1:0] lv;
        logic [LW-1:0] pk;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vu_level_meter #(
        .S_WIDTH      (SW),
        .L_WIDTH      (LW),
        .HOLD_FRAMES  (3),
        .DECAY_FRAMES (1)
    ) dut (
        .pixel_clock  (clk),
        .reset        (rst_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_start  (frame_start),
        .level        (level),
        .peak         (peak),
        .level_valid  (level_valid)
    );

    // Monitor: every level_valid must match the oldest expectation, at the
    // exact expected cycle; an expectation whose cycle passes is a miss.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missed_pulse: no level_valid at cycle %0d (now %0d), expected level %0d peak %0d",
                     exp_q[0].cyc, cyc, exp_q[0].lv, exp_q[0].pk);
            void'(exp_q.pop_front());
        end
        if (level_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: level_valid at cycle %0d with level %0d peak %0d, none expected",
                         cyc, level, peak);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc != e.cyc || level != e.lv || peak != e.pk) begin
                    n_fail++;
                    $display("FAIL update: got cycle %0d level %0d peak %0d, expected cycle %0d level %0d peak %0d",
                             cyc, level, peak, e.cyc, e.lv, e.pk);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic send(input int s);
        int n;
        sample       = SW'(s);
        sample_valid = 1'b1;
        n = 0;
        while (!sample_ready && n < 20) begin
            tick();
            n++;
        end
        if (!sample_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: sample_ready stayed 0, expected 1");
        end
        tick();
        sample_valid = 1'b0;
    endtask

    // Pulse frame_start (optionally also during UPDATE, where it must be
    // ignored) and expect the update two cycles later.
    task automatic do_frame(input logic [LW-1:0] el, input logic [LW-1:0] ep, input bit hold2);
        frame_start = 1'b1;
        exp_q.push_back('{cyc + 2, el, ep});
        tick();
        if (!hold2) frame_start = 1'b0;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        sample       = '0;
        sample_valid = 1'b0;
        frame_start  = 1'b0;

        // Reset sequence.
        repeat (3) tick();
        chk("rst_ready", int'(sample_ready), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_peak", int'(peak), 0);
        chk("rst_valid", int'(level_valid), 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", int'(sample_ready), 1);
        tick();

        // Full-scale window: most negative sample saturates to 2047 -> 15.
        send(-2048);
        do_frame(4'd15, 4'd15, 1'b0);

        // Silent frames: level decays every frame, peak holds 3 frames.
        do_frame(4'd14, 4'd15, 1'b0);
        do_frame(4'd13, 4'd15, 1'b1);
        do_frame(4'd12, 4'd15, 1'b0);
        do_frame(4'd11, 4'd14, 1'b0);

        // Window maximum: max(|256|, |-640|) = 640 -> 640 >> 7 = 5.
        do_reset();
        send(256);
        send(-640);
        do_frame(4'd5, 4'd5, 1'b0);
        // Smaller raw (128 -> 1): level steps down, peak held.
        send(128);
        do_frame(4'd4, 4'd5, 1'b0);

        // Handshake edges.
        do_reset();
        sample       = SW'(1024);
        sample_valid = 1'b1;
        frame_start  = 1'b1;
        exp_q.push_back('{cyc + 2, 4'd8, 4'd8});
        tick();
        frame_start = 1'b0;
        sample      = SW'(1920);
        chk("ready_in_update", int'(sample_ready), 0);
        tick();
        chk("ready_after_update", int'(sample_ready), 1);
        tick();
        sample_valid = 1'b0;
        do_frame(4'd15, 4'd15, 1'b0);

        // Reset during UPDATE aborts the update.
        send(2000);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        rst_n       = 1'b0;
        tick();
        chk("midrst_level", int'(level), 0);
        chk("midrst_peak", int'(peak), 0);
        chk("midrst_valid", int'(level_valid), 0);
        chk("midrst_ready", int'(sample_ready), 0);
        rst_n = 1'b1;
        tick();
        tick();
        do_frame(4'd0, 4'd0, 1'b0);

        repeat (4) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_vu_level_meter
